// File: rtl/zero_run_window_ctrl.sv
// Window sequencer for an external zero-run counter: frames win_len valid bits,
// drives counter enable/clear, tracks the longest zero run and hands it off via valid/ready.
module zero_run_window_ctrl #(
    parameter int CNT_W = 4,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             NOT_RESET,
    input  logic             start,
    input  logic             abort,
    input  logic [LEN_W-1:0] win_len,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic [CNT_W-1:0] cnt_value,
    output logic             cnt_en,
    output logic             cnt_clr,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] res_max_run,
    output logic             res_sat
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_max;
    logic [LEN_W-1:0] r_bits_left;
    logic             r_sat;

    logic             w_cnt_full;
    logic [CNT_W-1:0] w_new_max;
    logic             w_start_ok;

    assign w_cnt_full  = &cnt_value;
    assign w_new_max   = (cnt_value > r_max) ? cnt_value : r_max;
    assign w_start_ok  = start && (win_len != '0);
    assign res_max_run = r_max;
    assign res_sat     = r_sat;

    always_comb begin
        w_next    = r_state;
        cnt_en    = 1'b0;
        cnt_clr   = 1'b0;
        busy      = (r_state != S_IDLE);
        res_valid = (r_state == S_DONE);
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) w_next = S_CLEAR;
            end
            S_CLEAR: begin
                cnt_clr = 1'b1;
                w_next  = S_RUN;
            end
            S_RUN: begin
                if (bit_valid) begin
                    // A zero at a full counter is dropped and flagged as saturation.
                    if (bit_in)           cnt_clr = 1'b1;
                    else if (!w_cnt_full) cnt_en  = 1'b1;
                    if (r_bits_left == LEN_W'(1)) w_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                w_next = S_DONE;
            end
            S_DONE: begin
                if (res_ready) begin
                    cnt_clr = 1'b1;
                    w_next  = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
        if (abort && (r_state != S_IDLE)) begin
            cnt_clr = 1'b1;
            cnt_en  = 1'b0;
            w_next  = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge NOT_RESET) begin
        if (NOT_RESET) begin
            r_state     <= S_IDLE;
            r_max       <= '0;
            r_bits_left <= '0;
            r_sat       <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) r_bits_left <= win_len;
                end
                S_CLEAR: begin
                    r_max <= '0;
                    r_sat <= 1'b0;
                end
                S_RUN: begin
                    if (!abort) begin
                        r_max <= w_new_max;
                        if (bit_valid) begin
                            r_bits_left <= r_bits_left - LEN_W'(1);
                            if (!bit_in && w_cnt_full) r_sat <= 1'b1;
                        end
                    end
                end
                S_CAPTURE: begin
                    // Picks up a zero run that ends on the window's last bit.
                    if (!abort) r_max <= w_new_max;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_zero_run_window_ctrl.sv
// Directed bench for zero_run_window_ctrl with a behavioural zero-run counter attached.
module tb_zero_run_window_ctrl;
    localparam int CNT_W = 4;
    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             NOT_RESET = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [LEN_W-1:0] win_len = '0;
    logic             bit_valid = 1'b0;
    logic             bit_in = 1'b0;
    logic [CNT_W-1:0] cnt_value;
    logic             cnt_en, cnt_clr, busy, res_valid;
    logic             res_ready = 1'b0;
    logic [CNT_W-1:0] res_max_run;
    logic             res_sat;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    int t0;
    logic seen;

    zero_run_window_ctrl #(.CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .NOT_RESET(NOT_RESET), .start(start), .abort(abort),
        .win_len(win_len), .bit_valid(bit_valid), .bit_in(bit_in),
        .cnt_value(cnt_value), .cnt_en(cnt_en), .cnt_clr(cnt_clr),
        .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
        .res_max_run(res_max_run), .res_sat(res_sat)
    );

    always #5 clk = ~clk;

    // The counter the controller sequences: clear beats enable.
    logic [CNT_W-1:0] r_cnt;
    always_ff @(posedge clk or posedge NOT_RESET) begin
        if (NOT_RESET)    r_cnt <= '0;
        else if (cnt_clr) r_cnt <= '0;
        else if (cnt_en)  r_cnt <= r_cnt + 1'b1;
    end
    assign cnt_value = r_cnt;

    always_ff @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_win(input int len);
        t0 = cyc;
        start = 1'b1; win_len = LEN_W'(len);
        @(negedge clk);
        start = 1'b0;
        chk("clear_pulse", {31'd0, cnt_clr}, 1);
        chk("busy_clear", {31'd0, busy}, 1);
        @(negedge clk);
    endtask

    task automatic feed(input logic b, input int gap);
        bit_valid = 1'b1; bit_in = b;
        #1;
        chk("cnt_clr_bit", {31'd0, cnt_clr}, {31'd0, b});
        chk("cnt_en_bit", {31'd0, cnt_en}, {31'd0, (!b && r_cnt != 4'hF)});
        @(negedge clk);
        bit_valid = 1'b0; bit_in = 1'b0;
        for (int g = 0; g < gap; g++) begin
            chk("busy_gap", {31'd0, busy}, 1);
            @(negedge clk);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!res_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", {31'd0, res_valid}, 1);
    endtask

    task automatic handshake(input int keep_max);
        res_ready = 1'b1;
        #1;
        chk("hs_clr", {31'd0, cnt_clr}, 1);
        @(negedge clk);
        res_ready = 1'b0;
        chk("hs_busy", {31'd0, busy}, 0);
        chk("hs_valid", {31'd0, res_valid}, 0);
        chk("hs_hold_max", {28'd0, res_max_run}, keep_max);
    endtask

    logic [7:0] pat1;

    initial begin
        // Reset state
        #2;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_valid", {31'd0, res_valid}, 0);
        chk("rst_en", {31'd0, cnt_en}, 0);
        chk("rst_clr", {31'd0, cnt_clr}, 0);
        chk("rst_max", {28'd0, res_max_run}, 0);
        chk("rst_sat", {31'd0, res_sat}, 0);
        @(negedge clk);
        NOT_RESET = 1'b0;
        @(negedge clk);

        // 1: 0,0,1,0,0,0,1,0 -> max 3, valid in cycle 11 counting the start cycle as 0
        pat1 = 8'b0100_0100;
        start_win(8);
        for (int i = 0; i < 8; i++) feed(pat1[i], 0);
        chk("t1_capture_not_valid", {31'd0, res_valid}, 0);
        wait_done();
        chk("t1_latency", cyc - t0, 11);
        chk("t1_max", {28'd0, res_max_run}, 3);
        chk("t1_sat", {31'd0, res_sat}, 0);
        handshake(3);

        // 2: 20 zeros -> saturates at 15
        start_win(20);
        for (int i = 0; i < 20; i++) feed(1'b0, 0);
        wait_done();
        chk("t2_max", {28'd0, res_max_run}, 15);
        chk("t2_sat", {31'd0, res_sat}, 1);
        handshake(15);

        // 3: 1,0,0,0 with 3-cycle gaps
        start_win(4);
        feed(1'b1, 3); feed(1'b0, 3); feed(1'b0, 3); feed(1'b0, 3);
        wait_done();
        chk("t3_max", {28'd0, res_max_run}, 3);
        chk("t3_sat", {31'd0, res_sat}, 0);
        handshake(3);

        // 4: result held under back-pressure, start ignored in DONE
        start_win(3);
        feed(1'b0, 0); feed(1'b1, 0); feed(1'b0, 0);
        wait_done();
        for (int i = 0; i < 5; i++) begin
            start = (i == 2); win_len = 8'd5;
            @(negedge clk);
            chk("t4_valid_hold", {31'd0, res_valid}, 1);
            chk("t4_max_hold", {28'd0, res_max_run}, 1);
        end
        start = 1'b0;
        handshake(1);
        @(negedge clk);
        chk("t4_idle_after", {31'd0, busy}, 0);

        // 5: abort after 3 bits of 10
        start_win(10);
        feed(1'b0, 0); feed(1'b0, 0); feed(1'b0, 0);
        abort = 1'b1;
        #1;
        chk("t5_abort_clr", {31'd0, cnt_clr}, 1);
        @(negedge clk);
        abort = 1'b0;
        chk("t5_idle", {31'd0, busy}, 0);
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (res_valid) seen = 1'b1;
            @(negedge clk);
        end
        chk("t5_no_valid", {31'd0, seen}, 0);

        // 6: asynchronous reset mid-RUN, then a zero-length start
        start_win(10);
        feed(1'b0, 0); feed(1'b0, 0); feed(1'b0, 0);
        bit_valid = 1'b1; bit_in = 1'b0;
        @(posedge clk);
        #2;
        NOT_RESET = 1'b1;
        #1;
        chk("t6_busy", {31'd0, busy}, 0);
        chk("t6_valid", {31'd0, res_valid}, 0);
        chk("t6_max", {28'd0, res_max_run}, 0);
        chk("t6_sat", {31'd0, res_sat}, 0);
        chk("t6_en", {31'd0, cnt_en}, 0);
        chk("t6_clr", {31'd0, cnt_clr}, 0);
        @(negedge clk);
        bit_valid = 1'b0;
        NOT_RESET = 1'b0;
        @(negedge clk);
        start = 1'b1; win_len = '0;
        @(negedge clk);
        start = 1'b0;
        chk("t6_len0_idle", {31'd0, busy}, 0);
        @(negedge clk);
        chk("t6_len0_still_idle", {31'd0, busy}, 0);
        chk("t6_len0_no_clr", {31'd0, cnt_clr}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end
endmodule
